ihp13_sram_bist_ctrl: RTL
=========================

// Module: ihp13_sram_bist_ctrl
// PURPOSE
//  Memory BIST initiator for one IHP13 RM_IHPSG13_1P_*_bm_bist SRAM macro: drives the A_BIST_* port
//  with a March C- sequence, checks the read data and reports pass/fail plus the first failing
//  address and element. Instantiated next to each SRAM cut; the cut's A_BIST_* port is driven
//  from here instead of being tied off.
// PARAMETERS
//  NumWords   256  words in the macro; any value 2..2048, power of two not required
//  DataWidth  64   macro word width
//  AddrWidth  $clog2(NumWords)  derived, do not override
//  StopOnFail 1    1: stop at the first mismatch; 0: finish the run, keep only the first failure
// PORTS
//  clk_i         in   1          clock; also wired to the macro's A_BIST_CLK at integration
//  rst_i         in   1          asynchronous, active-high reset
//  start_i       in   1          run request, sampled in IDLE/DONE only
//  busy_o        out  1          a run is in progress
//  done_o        out  1          run finished; held until the next accepted start
//  fail_o        out  1          a mismatch occurred in the current/last run (sticky)
//  fail_addr_o   out  AddrWidth  address of the first mismatch
//  fail_elem_o   out  3          March element index (0..5) of the first mismatch
//  bist_en_o     out  1          to A_BIST_EN; high whenever busy_o is high
//  bist_men_o    out  1          to A_BIST_MEN
//  bist_wen_o    out  1          to A_BIST_WEN
//  bist_ren_o    out  1          to A_BIST_REN
//  bist_addr_o   out  AddrWidth  to A_BIST_ADDR
//  bist_din_o    out  DataWidth  to A_BIST_DIN
//  bist_bm_o     out  DataWidth  to A_BIST_BM; all ones while busy, 0 otherwise
//  bist_rdata_i  in   DataWidth  from A_DOUT
// BEHAVIOUR
//  Clocking: one clock; reset is asynchronous and active-high.
//  Reset: every output is 0 and the FSM is in IDLE. Reset mid-run aborts immediately; the macro
//   port returns to idle at once. No run resumes after reset is released.
//  FSM: IDLE -> RUN on start_i; RUN -> DRAIN after the last operation;
//   RUN -> DRAIN on a mismatch when StopOnFail=1; DRAIN -> DONE; DONE -> RUN on start_i.
//   start_i is ignored while in RUN or DRAIN.
//  Accepting start_i clears fail_o, fail_addr_o, fail_elem_o and done_o.
//  March C- elements (up = addr 0..NumWords-1, down = NumWords-1..0):
//   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
//   0 = all-zeros word; 1 = all-ones word.
//  Operation timing: one operation per cycle, no idle cycles between operations or elements,
//   10*NumWords operations in total.
//   - Start edge = cycle 0. Operations occupy cycles 1..10*NumWords.
//   - Cycle 10*NumWords+1 is DRAIN (last compare). done_o rises in cycle 10*NumWords+2.
//  Per operation: men=1; write: wen=1, ren=0, din=pattern; read: wen=0, ren=1, din=0.
//   Macro port outputs are decoded from registered state and counters, with no start_i->output path.
//  Read check: read latency is 1. The expected word and the address/element are registered with the
//   read; bist_rdata_i is compared in the following cycle (this overlaps the next operation).
//  First mismatch: sets fail_o and captures the registered address/element. Later mismatches never
//   overwrite them.
//   - StopOnFail=1: the operation issued in the compare cycle is the last one; the FSM then goes
//     DRAIN -> DONE, and a DRAIN compare cannot overwrite the capture.
//  Counters: the address counter wraps per element at NumWords-1 (up) or 0 (down), never beyond.
//   The element counter is 3 bits, saturating at E5.
//  busy_o: high in RUN and DRAIN. bist_en_o = busy_o. bist_men/wen/ren are 0 in DRAIN, IDLE and DONE.
// STRUCTURE
//  Package ihp13_bist_pkg: march_elem_e (E0..E5), march_op_e (OP_R, OP_W), per-element tables
//   (direction, op count, read/write polarity) as localparam functions, BIST_NUM_ELEMS=6.
//  Single module, no sub-module; address, element and op-in-element counters plus a 1-stage
//   compare register.
// TESTING
//  T1 fault-free behavioural 256x64 model, start pulse -> done_o high at cycle 2562, fail_o=0;
//   exactly 1280 writes and 1280 reads; busy_o high cycles 1..2561.
//  T2 bit 17 of addr 0x5A stuck-at-0 -> fail_o=1, fail_addr_o=0x5A, fail_elem_o=2; with
//   StopOnFail=1, done_o rises 2 cycles after the compare.
//  T3 bit 0 of addr 0x00 stuck-at-1 -> fail_elem_o=1, fail_addr_o=0; with StopOnFail=0 the run
//   still takes 2562 cycles and the capture is unchanged at the end.
//  T4 start_i held high throughout -> one run, second run starts the cycle after DONE is reached,
//   fail_o cleared; start pulses during RUN -> ignored, cycle count unchanged.
//  T5 rst_i asserted in the middle of E3 -> all outputs 0 before the next edge; after release,
//   start -> clean full run and pass.
//  T6 NumWords=200 (AddrWidth 8) -> bist_addr_o never exceeds 199; E3 begins at 199;
//   done_o rises at cycle 2002.

Source files
------------

// File: rtl/ihp13_bist_pkg.sv
// ihp13_bist_pkg: March C- element tables and FSM types for the IHP13 SRAM BIST controller
package ihp13_bist_pkg;
  localparam int BIST_NUM_ELEMS = 6;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_e;
  typedef enum logic {OP_R, OP_W} march_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} bist_state_e;
  function automatic logic elem_down(march_elem_e e);
    return e == E3 || e == E4;
  endfunction
  function automatic logic [1:0] elem_ops(march_elem_e e);
    return (e == E0 || e == E5) ? 2'd1 : 2'd2;
  endfunction
  function automatic march_op_e elem_op(march_elem_e e, logic idx);
    return (e == E0) ? OP_W : (e == E5 || !idx) ? OP_R : OP_W;
  endfunction
  function automatic logic elem_pol(march_elem_e e, logic idx);
    return (e == E1 || e == E3) ? idx : (e == E2 || e == E4) ? !idx : 1'b0;
  endfunction
endpackage

// File: rtl/ihp13_sram_bist_ctrl.sv
// ihp13_sram_bist_ctrl: March C- BIST initiator driving the A_BIST_* port of one IHP13 SRAM macro
module ihp13_sram_bist_ctrl
  import ihp13_bist_pkg::*;
#(
  parameter int NumWords   = 256,
  parameter int DataWidth  = 64,
  parameter int AddrWidth  = $clog2(NumWords),
  parameter bit StopOnFail = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  output logic                 bist_en_o,
  output logic                 bist_men_o,
  output logic                 bist_wen_o,
  output logic                 bist_ren_o,
  output logic [AddrWidth-1:0] bist_addr_o,
  output logic [DataWidth-1:0] bist_din_o,
  output logic [DataWidth-1:0] bist_bm_o,
  input  logic [DataWidth-1:0] bist_rdata_i
);
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam march_elem_e LastElem = march_elem_e'(3'(BIST_NUM_ELEMS - 1));
  bist_state_e r_state, w_state_nxt;
  march_elem_e r_elem, r_cmp_elem, w_elem_nxt;
  logic [AddrWidth-1:0] r_addr, r_cmp_addr, r_fail_addr;
  logic [2:0] r_fail_elem;
  logic r_op, r_cmp_vld, r_cmp_exp, r_fail, r_done;
  logic w_run, w_accept, w_wr, w_pol, w_last_op, w_last_addr, w_last, w_mismatch;
  assign w_run       = r_state == S_RUN;
  assign w_accept    = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_wr        = elem_op(r_elem, r_op) == OP_W;
  assign w_pol       = elem_pol(r_elem, r_op);
  assign w_last_op   = {1'b0, r_op} == elem_ops(r_elem) - 2'd1;
  assign w_last_addr = elem_down(r_elem) ? (r_addr == '0) : (r_addr == LastAddr);
  assign w_last      = w_last_op && w_last_addr && r_elem == LastElem;
  assign w_elem_nxt  = (r_elem == LastElem) ? r_elem : march_elem_e'(r_elem + 3'd1);
  assign w_mismatch  = r_cmp_vld && (bist_rdata_i != {DataWidth{r_cmp_exp}});
  // state register; reset aborts any run and parks in IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  // next state: runs end after the last op, or at the first mismatch when stopping on fail
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_state_nxt = w_accept ? S_RUN : r_state;
      S_RUN:          w_state_nxt = (w_last || (StopOnFail && w_mismatch)) ? S_DRAIN : S_RUN;
      S_DRAIN:        w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end
  // element / address / op-in-element counters; each element restarts at its own end of the array
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_accept) begin
      r_elem <= E0;
      r_addr <= '0;
      r_op   <= 1'b0;
    end else if (w_run) begin
      if (!w_last_op) r_op <= 1'b1;
      else begin
        r_op <= 1'b0;
        if (w_last_addr) begin
          r_elem <= w_elem_nxt;
          r_addr <= elem_down(w_elem_nxt) ? LastAddr : '0;
        end else r_addr <= elem_down(r_elem) ? r_addr - AddrWidth'(1) : r_addr + AddrWidth'(1);
      end
    end
  end
  // read data arrives one cycle after the read, so expectation and location travel with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= 1'b0;
      r_cmp_addr <= '0;
      r_cmp_elem <= E0;
    end else begin
      r_cmp_vld  <= w_run && !w_wr;
      r_cmp_exp  <= w_pol;
      r_cmp_addr <= r_addr;
      r_cmp_elem <= r_elem;
    end
  end
  // sticky first-failure capture and done flag, both cleared by an accepted start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_accept) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_mismatch && !r_fail) begin
        r_fail      <= 1'b1;
        r_fail_addr <= r_cmp_addr;
        r_fail_elem <= r_cmp_elem;
      end
      if (r_state == S_DRAIN) r_done <= 1'b1;
    end
  end
  assign busy_o      = r_state == S_RUN || r_state == S_DRAIN;
  assign done_o      = r_done;
  assign fail_o      = r_fail;
  assign fail_addr_o = r_fail_addr;
  assign fail_elem_o = r_fail_elem;
  assign bist_en_o   = busy_o;
  assign bist_men_o  = w_run;
  assign bist_wen_o  = w_run && w_wr;
  assign bist_ren_o  = w_run && !w_wr;
  assign bist_addr_o = w_run ? r_addr : '0;
  assign bist_din_o  = (w_run && w_wr) ? {DataWidth{w_pol}} : '0;
  assign bist_bm_o   = {DataWidth{busy_o}};
endmodule
